alu_nibble_sequencer: RTL and testbench

- Initiator that drives the team's combinational 4-bit ALU (ports a, b, alu_op, result, carry_out, zero) to execute 8-bit operations as nibble passes.
- Accepts 8-bit requests over valid/ready, issues 2–3 ALU passes (low nibble, high nibble, optional carry/borrow fix-up), then returns an 8-bit result with carry and zero over valid/ready.
- Sits between a control FSM or register file and the ALU instance.

---
 rtl/alu_nibble_sequencer_if.sv | 34 +++
 rtl/alu_nibble_sequencer.sv | 134 +++++++++++++
 tb/tb_alu_nibble_sequencer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/alu_nibble_sequencer_if.sv
// Request/response handshake plus the nibble-ALU bus of the sequencer.
// slave = sequencer side, master = requester/consumer and ALU side.
interface alu_nibble_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_carry;
  logic       rsp_zero;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_op;
  logic [3:0] alu_result;
  logic       alu_carry_out;
  logic       alu_zero;

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
           alu_result, alu_carry_out, alu_zero,
    output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero,
           alu_a, alu_b, alu_op
  );

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
           alu_result, alu_carry_out, alu_zero,
    input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero,
           alu_a, alu_b, alu_op
  );
endinterface

// File: rtl/alu_nibble_sequencer.sv
// Runs 8-bit ops on a combinational 4-bit ALU as low/high/fix-up nibble passes.
// ALU_SEQ_PERF_EN adds op_count and the sticky flag_mismatch ALU zero check.
module alu_nibble_sequencer (
  input  logic clk,
  input  logic rst_n,
  alu_nibble_sequencer_if.slave bus
`ifdef ALU_SEQ_PERF_EN
  ,
  output logic [15:0] op_count,
  output logic        flag_mismatch
`endif
);
  typedef enum logic [2:0] {IDLE, LO, HI, FIX, RESP} state_t;
  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } req_t;

  state_t     state_q, state_d;
  req_t       req_q;
  logic [3:0] r_l, r_h;
  logic       c_l, c_h;
  logic       arith, load_rsp;
  logic [3:0] hi_sel;
  logic       cy_sel;
  logic [8:0] asm_res;

  // {carry, result}; shifts rebuild the bit that crosses the nibble seam from a.
  function automatic logic [8:0] assemble(input logic [2:0] op, input logic [7:0] a,
                                          input logic [3:0] lo, input logic [3:0] hi,
                                          input logic cy);
    case (op)
      3'b000, 3'b001: assemble = {cy, hi, lo};
      3'b110:         assemble = {a[7], hi[3:1], a[3], lo};
      3'b111:         assemble = {a[0], hi, a[4], lo[2:0]};
      default:        assemble = {1'b0, hi, lo};
    endcase
  endfunction

  assign arith         = (req_q.op[2:1] == 2'b00);
  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;

  always_comb begin
    state_d    = state_q;
    bus.alu_a  = 4'h0;
    bus.alu_b  = 4'h0;
    bus.alu_op = 3'b000;
    case (state_q)
      IDLE: if (bus.req_valid) state_d = LO;
      LO: begin
        bus.alu_a  = req_q.a[3:0];
        bus.alu_b  = req_q.b[3:0];
        bus.alu_op = req_q.op;
        state_d    = HI;
      end
      HI: begin
        bus.alu_a  = req_q.a[7:4];
        bus.alu_b  = req_q.b[7:4];
        bus.alu_op = req_q.op;
        state_d    = (arith && c_l) ? FIX : RESP;
      end
      FIX: begin
        bus.alu_a  = r_h;
        bus.alu_b  = 4'h1;
        bus.alu_op = req_q.op;
        state_d    = RESP;
      end
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The current pass is the last one when HI skips FIX, or in FIX itself.
  assign load_rsp = ((state_q == HI) && (state_d == RESP)) || (state_q == FIX);
  assign hi_sel   = bus.alu_result;
  assign cy_sel   = (state_q == FIX) ? (c_h | bus.alu_carry_out)
                                     : (bus.alu_carry_out & arith);
  assign asm_res  = assemble(req_q.op, req_q.a, r_l, hi_sel, cy_sel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q          <= '0;
      r_l            <= 4'h0;
      r_h            <= 4'h0;
      c_l            <= 1'b0;
      c_h            <= 1'b0;
      bus.rsp_result <= 8'h00;
      bus.rsp_carry  <= 1'b0;
      bus.rsp_zero   <= 1'b0;
    end else begin
      if (state_q == IDLE && bus.req_valid)
        req_q <= '{op: bus.req_op, a: bus.req_a, b: bus.req_b};
      if (state_q == LO) begin
        r_l <= bus.alu_result;
        c_l <= bus.alu_carry_out & arith;
      end
      if (state_q == HI) begin
        r_h <= bus.alu_result;
        c_h <= bus.alu_carry_out & arith;
      end
      if (load_rsp) begin
        bus.rsp_result <= asm_res[7:0];
        bus.rsp_carry  <= asm_res[8];
        bus.rsp_zero   <= (asm_res[7:0] == 8'h00);
      end
    end
  end

`ifdef ALU_SEQ_PERF_EN
  logic logic_op;
  assign logic_op = (req_q.op >= 3'd2) && (req_q.op <= 3'd5);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count      <= 16'h0000;
      flag_mismatch <= 1'b0;
    end else begin
      if (bus.rsp_valid && bus.rsp_ready) op_count <= op_count + 16'h0001;
      if ((state_q == LO || state_q == HI) && logic_op &&
          (bus.alu_zero != (bus.alu_result == 4'h0)))
        flag_mismatch <= 1'b1;
    end
  end
`else
  logic unused_alu_zero;
  assign unused_alu_zero = bus.alu_zero;
`endif
endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Directed and random ops on alu_nibble_sequencer against an 8-bit arithmetic reference.
module tb_alu_nibble_sequencer;
  logic clk, rst_n;
  logic stale_cy;
  int   checks, failures;
  int   exp_cnt;
`ifdef ALU_SEQ_PERF_EN
  logic [15:0] op_count;
  logic        flag_mismatch;
`endif

  alu_nibble_sequencer_if bus();

  alu_nibble_sequencer dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
`ifdef ALU_SEQ_PERF_EN
    , .op_count(op_count), .flag_mismatch(flag_mismatch)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 4-bit ALU; for non-arith ops carry_out holds an arbitrary stale value.
  always_comb begin
    logic [4:0] t;
    t = 5'h00;
    bus.alu_carry_out = stale_cy;
    case (bus.alu_op)
      3'b000: begin t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b}; bus.alu_carry_out = t[4]; end
      3'b001: begin t = {1'b0, bus.alu_a} - {1'b0, bus.alu_b}; bus.alu_carry_out = t[4]; end
      3'b010: t[3:0] = bus.alu_a & bus.alu_b;
      3'b011: t[3:0] = bus.alu_a | bus.alu_b;
      3'b100: t[3:0] = bus.alu_a ^ bus.alu_b;
      3'b101: t[3:0] = ~(bus.alu_a | bus.alu_b);
      3'b110: t[3:0] = {bus.alu_a[2:0], 1'b0};
      default: t[3:0] = {1'b0, bus.alu_a[3:1]};
    endcase
    bus.alu_result = t[3:0];
    bus.alu_zero   = (t[3:0] == 4'h0);
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {carry, result} straight from 8-bit arithmetic.
  function automatic logic [8:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: model = {1'b0, a} + {1'b0, b};
      3'd1: model = {(a < b), a - b};
      3'd2: model = {1'b0, a & b};
      3'd3: model = {1'b0, a | b};
      3'd4: model = {1'b0, a ^ b};
      3'd5: model = {1'b0, ~(a | b)};
      3'd6: model = {a[7], a << 1};
      default: model = {a[0], a >> 1};
    endcase
  endfunction

  function automatic int latency(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int lo_a, lo_b;
    lo_a = int'(a[3:0]);
    lo_b = int'(b[3:0]);
    if (op == 3'd0 && lo_a + lo_b > 15) return 3;
    if (op == 3'd1 && lo_a < lo_b) return 3;
    return 2;
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input int hold, input bit poke);
    logic [8:0] m;
    int lat, n;
    m   = model(op, a, b);
    lat = latency(op, a, b);
    @(negedge clk);
    check("req_ready_idle", {15'd0, bus.req_ready}, 16'd1);
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("latency op%0d %h,%h", op, a, b), 16'(n), 16'(lat));
    check($sformatf("result op%0d %h,%h", op, a, b), {8'd0, bus.rsp_result}, {8'd0, m[7:0]});
    check($sformatf("carry op%0d %h,%h", op, a, b), {15'd0, bus.rsp_carry}, {15'd0, m[8]});
    check($sformatf("zero op%0d %h,%h", op, a, b), {15'd0, bus.rsp_zero}, {15'd0, m[7:0] == 8'h00});
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        bus.req_valid = 1'b1; bus.req_op = 3'd0; bus.req_a = ~a; bus.req_b = ~b;
      end
      @(posedge clk); #1;
      check("hold_valid", {15'd0, bus.rsp_valid}, 16'd1);
      check("hold_result", {7'd0, bus.rsp_carry, bus.rsp_result}, {7'd0, m});
      check("hold_req_ready", {15'd0, bus.req_ready}, 16'd0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    exp_cnt++;
    check("rsp_done", {15'd0, bus.rsp_valid}, 16'd0);
    check("ready_back", {15'd0, bus.req_ready}, 16'd1);
`ifdef ALU_SEQ_PERF_EN
    check("op_count", op_count, 16'(exp_cnt));
`endif
  endtask

  initial begin
    checks = 0; failures = 0; exp_cnt = 0;
    stale_cy = 1'b0;
    bus.req_valid = 1'b0; bus.req_op = 3'd0; bus.req_a = 8'h00; bus.req_b = 8'h00;
    bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    #3;
    check("rst_rsp_valid", {15'd0, bus.rsp_valid}, 16'd0);
    check("rst_rsp", {6'd0, bus.rsp_carry, bus.rsp_zero, bus.rsp_result}, 16'd0);
    check("rst_alu", {5'd0, bus.alu_op, bus.alu_a, bus.alu_b}, 16'd0);
    #14 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_req_ready", {15'd0, bus.req_ready}, 16'd1);
`ifdef ALU_SEQ_PERF_EN
    check("rst_op_count", op_count, 16'd0);
`endif

    run_op(3'd0, 8'h8F, 8'h01, 0, 1'b0);
    run_op(3'd0, 8'hFF, 8'h01, 0, 1'b0);
    run_op(3'd0, 8'h12, 8'h34, 1, 1'b0);
    run_op(3'd1, 8'h10, 8'h01, 0, 1'b0);
    run_op(3'd1, 8'h00, 8'h01, 0, 1'b0);
    run_op(3'd1, 8'h55, 8'h55, 0, 1'b0);
    stale_cy = 1'b1;
    run_op(3'd6, 8'h88, 8'h00, 0, 1'b0);
    run_op(3'd7, 8'h81, 8'h00, 0, 1'b0);
    run_op(3'd5, 8'hF0, 8'h0F, 0, 1'b0);
    run_op(3'd4, 8'hA5, 8'hFF, 5, 1'b1);
    run_op(3'd0, 8'h01, 8'h02, 0, 1'b0);

    // Reset during the HI pass of an add abandons it.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = 3'd0; bus.req_a = 8'h8F; bus.req_b = 8'h11;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #2;
    check("hi_alu_a", {12'd0, bus.alu_a}, 16'h0008);
    rst_n = 1'b0;
    #1;
    check("midrst_alu", {5'd0, bus.alu_op, bus.alu_a, bus.alu_b}, 16'd0);
    check("midrst_rsp", {6'd0, bus.rsp_carry, bus.rsp_zero, bus.rsp_result}, 16'd0);
    check("midrst_valid", {15'd0, bus.rsp_valid}, 16'd0);
    exp_cnt = 0;
`ifdef ALU_SEQ_PERF_EN
    check("midrst_op_count", op_count, 16'd0);
`endif
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("no_rsp_after_rst", {15'd0, bus.rsp_valid}, 16'd0);
    end
    run_op(3'd0, 8'h8F, 8'h11, 0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      stale_cy = 1'($urandom_range(0, 1));
      run_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
             int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end
`ifdef ALU_SEQ_PERF_EN
    check("flag_mismatch", {15'd0, flag_mismatch}, 16'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
